// File: rtl/controlador_soma16.sv
// Nibble-serial add/subtract controller: drives an external shared 4-bit ripple
// adder for N_NIB cycles, assembling a 4*N_NIB-bit result LSB nibble first.
module controlador_soma16 #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [4*N_NIB-1:0]   A,
  input  logic [4*N_NIB-1:0]   B,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  input  logic                 add_c3,
  output logic [4*N_NIB-1:0]   S,
  output logic                 Cout,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = 4 * N_NIB;
  // One spare count so idx can step past the last nibble without wrapping.
  localparam int IW = $clog2(N_NIB + 1);
  localparam logic [IW-1:0] LAST = IW'(N_NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg, b_reg;
  logic          carry_reg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= op_sub ? ~B : B;
            carry_reg <= op_sub;
            idx       <= '0;
          end
        end
        RUN: begin
          S[{idx, 2'b00} +: 4] <= add_s;
          carry_reg            <= add_cout;
          idx                  <= idx + 1'b1;
          if (idx == LAST) begin
            Cout     <= add_cout;
            overflow <= add_c3 ^ add_cout;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        add_a   = a_reg[{idx, 2'b00} +: 4];
        add_b   = b_reg[{idx, 2'b00} +: 4];
        add_cin = carry_reg;
        if (idx == LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_controlador_soma16.sv
// Scoreboard bench for controlador_soma16 with a behavioural 4-bit adder and an
// arithmetic reference model of results, timing and adder-port traffic.
module tb_controlador_soma16;

  localparam int N_NIB = 4;
  localparam int W     = 4 * N_NIB;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout, add_c3;
  logic [W-1:0] S;
  logic         Cout, overflow, busy, done;
  logic [3:0]   low3;

  controlador_soma16 #(.N_NIB(N_NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .A(A), .B(B),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_c3(add_c3),
    .S(S), .Cout(Cout), .overflow(overflow), .busy(busy), .done(done)
  );

  // Shared external adder: plain 4-bit sum, carry out, and carry into bit 3.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign low3              = {1'b0, add_a[2:0]} + {1'b0, add_b[2:0]} + {3'd0, add_cin};
  assign add_c3            = low3[3];

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  int   rem = 0;
  logic [W-1:0] a_m = '0;
  logic [W-1:0] b_m = '0;
  logic         op_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-word arithmetic view of the operation.
  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    int   ru, rs;
    ru  = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    rs  = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    r.s = ru[W-1:0];
    r.c = sub ? (a >= b) : (ru > 65535);
    r.o = (rs > 32767) || (rs < -32768);
    return r;
  endfunction

  // Carry entering nibble i of (a + bm + c), taken from the low-part sum.
  function automatic logic cin_at(input logic [W-1:0] a, input logic [W-1:0] bm,
                                  input logic c, input int i);
    int mask, t;
    mask = (1 << (4 * i)) - 1;
    t    = (int'(a) & mask) + (int'(bm) & mask) + int'(c);
    return ((t >> (4 * i)) & 1) != 0;
  endfunction

  // Reference model: an accepted request keeps the block busy N_NIB+1 cycles.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      rem = 0;
      exp_q.delete();
    end else if (rem == 0) begin
      if (start) begin
        a_m  = A;
        b_m  = op_sub ? ~B : B;
        op_m = op_sub;
        exp_q.push_back(ref_op(A, B, op_sub));
        rem  = N_NIB + 1;
      end
    end else begin
      rem--;
    end
  end

  // Monitor: per-cycle status, adder traffic, and scoreboard pop on done.
  initial begin
    res_t hold_val;
    res_t e;
    int   i;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (rst) hold_val = '0;
      check("busy", busy, rem != 0);
      check("done", done, rem == 1);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("S", S, e.s);
          check("Cout", Cout, e.c);
          check("overflow", overflow, e.o);
          hold_val = e;
        end
      end else if (rem == 0) begin
        check("S_hold", S, hold_val.s);
        check("Cout_hold", Cout, hold_val.c);
        check("overflow_hold", overflow, hold_val.o);
      end
      if (rem >= 2) begin
        i = N_NIB + 1 - rem;
        check("add_a", add_a, a_m[4*i +: 4]);
        check("add_b", add_b, b_m[4*i +: 4]);
        check("add_cin", add_cin, cin_at(a_m, b_m, op_m, i));
      end else begin
        check("add_a_idle", add_a, 0);
        check("add_b_idle", add_b, 0);
        check("add_cin_idle", add_cin, 0);
      end
    end
  end

  // Issue one request once idle; measure latency to done; optionally check result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input logic directed);
    int n;
    n = 0;
    while (rem != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    A = a; B = b; op_sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); op_sub = 1'($urandom_range(0, 1));
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 5);
    if (directed) begin
      check("dir_S", S, es);
      check("dir_Cout", Cout, ec);
      check("dir_overflow", overflow, eo);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_S", S, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    repeat (30) do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), '0, 1'b0, 1'b0, 1'b0);

    // start held high with operands changing every cycle
    repeat (40) begin
      start = 1'b1;
      A = W'($urandom); B = W'($urandom); op_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    // start toggling randomly, including while busy
    repeat (150) begin
      start = 1'($urandom_range(0, 1));
      A = W'($urandom); B = W'($urandom); op_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    // reset during the second RUN cycle
    A = 16'h1234; B = 16'h4321; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_S", S, 0);
    check("arst_Cout", Cout, 0);
    check("arst_overflow", overflow, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_add_a", add_a, 0);
    check("arst_add_b", add_b, 0);
    check("arst_add_cin", add_cin, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    repeat (8) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
